// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder: producer side and consumer side
// valid/ready handshakes plus the operand and result buses.
// master = the environment driving operands and consuming results, slave = the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, one S-bit slice added per stage.
// Latency STAGES cycles from acceptance to out_valid, one result per cycle.
// Global stall: when out_valid && !out_ready every stage holds and in_ready=0.
module pipelined_adder #(
    parameter int WIDTH  = 16,   // >= 2, and the interface must use the same WIDTH
    parameter int STAGES = 4     // >= 1, must divide WIDTH exactly
) (
    input logic             clk,
    input logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int S    = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: operands still to be added (lower bits become
    // don't-care as slices are consumed), result bits so far, ripple carry,
    // the operand sign bits for overflow, and the valid flag.
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             am_q [STAGES];
    logic             bm_q [STAGES];
    logic             v_q  [STAGES];

    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] b_d  [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             c_d  [STAGES];
    logic             am_d [STAGES];
    logic             bm_d [STAGES];
    logic             v_d  [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is a + ~b + 1, so cin is overridden in subtract mode.
    assign b_eff   = bus.b ^ {WIDTH{bus.sub}};
    assign c_eff   = bus.sub | bus.cin;

    // The whole pipe moves together; bubbles travel as invalid entries.
    assign advance = !v_q[LAST] || bus.out_ready;

    // Each stage adds its own slice on top of what the previous stage registered.
    always_comb begin
        logic [WIDTH-1:0] a_s;
        logic [WIDTH-1:0] b_s;
        logic [WIDTH-1:0] s_s;
        logic             c_s;
        logic             am_s;
        logic             bm_s;
        logic             v_s;
        int               p;
        a_s  = '0;
        b_s  = '0;
        s_s  = '0;
        c_s  = 1'b0;
        am_s = 1'b0;
        bm_s = 1'b0;
        v_s  = 1'b0;
        p    = 0;
        for (int k = 0; k < STAGES; k++) begin
            p = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
                a_s  = bus.a;
                b_s  = b_eff;
                s_s  = '0;
                c_s  = c_eff;
                am_s = bus.a[MSB];
                bm_s = b_eff[MSB];
                v_s  = bus.in_valid;
            end else begin
                a_s  = a_q[p];
                b_s  = b_q[p];
                s_s  = s_q[p];
                c_s  = c_q[p];
                am_s = am_q[p];
                bm_s = bm_q[p];
                v_s  = v_q[p];
            end
            s_d[k] = s_s;
            {c_d[k], s_d[k][k*S +: S]} = {1'b0, a_s[k*S +: S]}
                                       + {1'b0, b_s[k*S +: S]}
                                       + {{S{1'b0}}, c_s};
            a_d[k]  = a_s;
            b_d[k]  = b_s;
            am_d[k] = am_s;
            bm_d[k] = bm_s;
            v_d[k]  = v_s;
        end
    end

    // Stage registers: cleared by reset, shifted on advance, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                am_q[k] <= 1'b0;
                bm_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                s_q[k]  <= s_d[k];
                c_q[k]  <= c_d[k];
                am_q[k] <= am_d[k];
                bm_q[k] <= bm_d[k];
                v_q[k]  <= v_d[k];
            end
        end
    end

    // Outputs come straight from the last stage; ovf only looks at registered bits.
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = (am_q[LAST] == bm_q[LAST]) && (s_q[LAST][MSB] != am_q[LAST]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded checks of pipelined_adder at 16/4, 8/1 and 32/8.
// One DUT is selected at a time; the others see in_valid=0 and out_ready=1.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        in_valid_t, cin_t, sub_t, out_ready_t;
    logic [31:0] a_t, b_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int acc_n    = 0;
    int rx_n     = 0;
    logic acc_flag, rx_flag;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) i16 ();
    pipelined_adder_if #(.WIDTH(8))  i8  ();
    pipelined_adder_if #(.WIDTH(32)) i32 ();

    assign i16.in_valid  = in_valid_t && (sel == 0);
    assign i16.a         = a_t[15:0];
    assign i16.b         = b_t[15:0];
    assign i16.cin       = cin_t;
    assign i16.sub       = sub_t;
    assign i16.out_ready = (sel == 0) ? out_ready_t : 1'b1;

    assign i8.in_valid   = in_valid_t && (sel == 1);
    assign i8.a          = a_t[7:0];
    assign i8.b          = b_t[7:0];
    assign i8.cin        = cin_t;
    assign i8.sub        = sub_t;
    assign i8.out_ready  = (sel == 1) ? out_ready_t : 1'b1;

    assign i32.in_valid  = in_valid_t && (sel == 2);
    assign i32.a         = a_t;
    assign i32.b         = b_t;
    assign i32.cin       = cin_t;
    assign i32.sub       = sub_t;
    assign i32.out_ready = (sel == 2) ? out_ready_t : 1'b1;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_add16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_add8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    pipelined_adder #(.WIDTH(32), .STAGES(8)) u_add32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    logic        obs_vld, obs_rdy, obs_cout, obs_ovf;
    logic [31:0] obs_sum;

    always_comb begin
        obs_vld  = 1'b0;
        obs_rdy  = 1'b0;
        obs_cout = 1'b0;
        obs_ovf  = 1'b0;
        obs_sum  = '0;
        case (sel)
            0: begin
                obs_vld = i16.out_valid; obs_rdy = i16.in_ready;
                obs_cout = i16.cout; obs_ovf = i16.ovf; obs_sum = {16'b0, i16.sum};
            end
            1: begin
                obs_vld = i8.out_valid; obs_rdy = i8.in_ready;
                obs_cout = i8.cout; obs_ovf = i8.ovf; obs_sum = {24'b0, i8.sum};
            end
            default: begin
                obs_vld = i32.out_valid; obs_rdy = i32.in_ready;
                obs_cout = i32.cout; obs_ovf = i32.ovf; obs_sum = i32.sum;
            end
        endcase
    end

    function automatic int cur_w();
        return (sel == 0) ? 16 : (sel == 1) ? 8 : 32;
    endfunction

    function automatic int cur_stages();
        return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
    endfunction

    // Reference result packed as {cout, ovf, sum}.
    function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                          logic cin, logic sub);
        logic [32:0] mask, beff, full;
        logic [31:0] s;
        logic        ceff, co, ov;
        mask = (33'd1 << w) - 33'd1;
        beff = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        ceff = sub ? 1'b1 : cin;
        full = ({1'b0, a} & mask) + beff + {32'b0, ceff};
        co   = full[w];
        s    = full[31:0] & mask[31:0];
        ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
        return {co, ov, s};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge after inputs are set: records the handshakes
    // that the next rising edge will perform, then advances one cycle.
    task automatic step();
        #1;
        acc_flag = 1'b0;
        rx_flag  = 1'b0;
        if (obs_vld && out_ready_t) begin
            rx_flag = 1'b1;
            rx_n++;
            if (exp_q.size() == 0) check("spurious_result", 1, 0);
            else check("sb_result", {obs_cout, obs_ovf, obs_sum}, exp_q.pop_front());
        end
        if (in_valid_t && obs_rdy) begin
            acc_flag = 1'b1;
            acc_n++;
            exp_q.push_back(model(cur_w(), a_t, b_t, cin_t, sub_t));
        end
        @(posedge clk);
        cyc_cnt++;
        @(negedge clk);
    endtask

    task automatic dir_op(string tag, logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                          logic [31:0] es, logic ec, logic eo);
        int edges;
        out_ready_t = 1'b1;
        a_t = a; b_t = b; cin_t = cin; sub_t = sub;
        in_valid_t = 1'b1;
        step();
        check({tag, "_acc"}, acc_flag, 1);
        in_valid_t = 1'b0;
        edges = 1;
        while (!obs_vld && edges < 40) begin
            step();
            edges++;
        end
        check({tag, "_lat"}, edges, cur_stages());
        check({tag, "_res"}, {obs_cout, obs_ovf, obs_sum}, {ec, eo, es});
        step();
        check({tag, "_drain"}, obs_vld, 0);
    endtask

    task automatic rand_stream(int n);
        int idx, c0, prev, cyc, rx0;
        idx = 0; c0 = -1; prev = -1; cyc = 0; rx0 = rx_n;
        out_ready_t = 1'b1;
        while ((idx < n || exp_q.size() > 0) && cyc < 200) begin
            in_valid_t = (idx < n);
            a_t = $urandom; b_t = $urandom;
            cin_t = 1'($urandom_range(0, 1)); sub_t = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (acc_flag) begin
                if (idx == 0) c0 = cyc_cnt - 1;
                idx++;
            end
            if (rx_flag) begin
                if (prev < 0) check("stream_first_lat", (cyc_cnt - 1) - c0, cur_stages());
                else check("stream_gap", (cyc_cnt - 1) - prev, 1);
                prev = cyc_cnt - 1;
            end
        end
        in_valid_t = 1'b0;
        check("stream_count", rx_n - rx0, n);
    endtask

    task automatic stall_stream(int n);
        logic [31:0] va[6], vb[6];
        logic [33:0] hold;
        int idx, cyc, rx0;
        logic stalled;
        for (int i = 0; i < 6; i++) begin
            va[i] = $urandom; vb[i] = $urandom;
        end
        idx = 0; cyc = 0; rx0 = rx_n; stalled = 1'b0;
        out_ready_t = 1'b1; cin_t = 1'b1; sub_t = 1'b0;
        while ((idx < n || exp_q.size() > 0) && cyc < 200) begin
            in_valid_t = (idx < n);
            a_t = va[idx % 6]; b_t = vb[idx % 6];
            if (obs_vld && !stalled) begin
                stalled = 1'b1;
                out_ready_t = 1'b0;
                #1;
                hold = {obs_cout, obs_ovf, obs_sum};
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("stall_in_ready", obs_rdy, 0);
                    check("stall_vld", obs_vld, 1);
                    check("stall_hold", {obs_cout, obs_ovf, obs_sum}, hold);
                    step();
                    cyc++;
                    if (acc_flag) idx++;
                end
                check("stall_hold_end", {obs_cout, obs_ovf, obs_sum}, hold);
                out_ready_t = 1'b1;
            end
            step();
            cyc++;
            if (acc_flag) idx++;
        end
        in_valid_t = 1'b0;
        check("stall_stalled", stalled, 1);
        check("stall_count", rx_n - rx0, n);
    endtask

    task automatic reset_flush();
        int acc0, bad;
        acc0 = acc_n;
        out_ready_t = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_t = 1'b1;
            a_t = $urandom; b_t = $urandom; cin_t = 1'b0; sub_t = 1'b0;
            step();
        end
        in_valid_t = 1'b0;
        check("flush_accepted", acc_n - acc0, 3);
        check("flush_pre_vld", obs_vld, 0);
        rst_n = 1'b0;
        #1;
        check("flush_vld", obs_vld, 0);
        check("flush_out", {obs_cout, obs_ovf, obs_sum}, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("flush_in_ready", obs_rdy, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_vld) bad++;
        end
        check("flush_stale", bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 0;
        in_valid_t = 1'b0; cin_t = 1'b0; sub_t = 1'b0; out_ready_t = 1'b1;
        a_t = '0; b_t = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_vld", obs_vld, 0);
            check("rst_out", {obs_cout, obs_ovf, obs_sum}, 0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", obs_rdy, 1);
        @(negedge clk);

        // WIDTH=16 STAGES=4
        dir_op("w16_carry", 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
        dir_op("w16_ovf",   32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
        dir_op("w16_sub",   32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0);
        rand_stream(8);
        stall_stream(6);
        reset_flush();

        // WIDTH=8 STAGES=1
        sel = 1;
        #1;
        dir_op("w8_carry", 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
        dir_op("w8_ovf",   32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
        dir_op("w8_sub",   32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0);

        // WIDTH=32 STAGES=8
        sel = 2;
        #1;
        dir_op("w32_carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir_op("w32_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir_op("w32_sub",   32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        rand_stream(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
